instr_control_unit: RTL
=======================

INSTR_CONTROL_UNIT -- requirements
Module: instr_control_unit

Interface
REQ-001 clock  in  1  sole clock; all state changes on rising edge.
REQ-002 clear  in  1  synchronous, active-high reset.
REQ-003 instruction  in  32  IR contents; opcode is [31:27].
REQ-004 con_ff  in  1  branch condition flip-flop; used only when CU_BRANCH_EN is defined.
REQ-005 PCout, MARin, IncPC, PCin  out  1 each  PC and MAR strobes; default 0.
REQ-006 Zin, Zlowout, Yin  out  1 each  ALU result and Y register strobes; default 0.
REQ-007 MDRin, MDRout, MD_read  out  1 each  MDR strobes; MD_read=1 selects memory data, 0 selects bus; default 0.
REQ-008 ram_read, ram_write, IRin  out  1 each  memory and IR strobes; default 0.
REQ-009 Gra, Grb, Grc, Rin, Rout, BAout, Cout  out  1 each  register-select and bus-drive strobes; default 0.
REQ-010 CONin  out  1  latch branch condition; default 0; present only with CU_BRANCH_EN.
REQ-011 alu_op  out  4  ADD=0000, SUB=0001, AND=0010, OR=0011; default ADD.
REQ-012 run  out  1  1 while executing; 0 in HALT.

Function
REQ-013 Moore FSM; every output shall be decoded from the current state and latched opcode only, with no input-to-output combinational path except via state.
REQ-014 States: RST, T0..T7, HALT; any unlisted strobe shall be 0 in a given state.
REQ-015 RST shall drive all strobes to 0 with run=1, then advance to T0.
REQ-016 Fetch: T0 PCout,MARin,IncPC,Zin; T1 Zlowout,PCin,ram_read,MD_read,MDRin; T2 MDRout,IRin; T3 shall decode instruction[31:27], captured at the end of T2.
REQ-017 ld (00000): T3 Grb,BAout,Yin; T4 Cout,Zin,ADD; T5 Zlowout,MARin; T6 ram_read,MD_read,MDRin; T7 MDRout,Gra,Rin; then T0.
REQ-018 ldi (00001): T3 Grb,BAout,Yin; T4 Cout,Zin,ADD; T5 Zlowout,Gra,Rin; then T0.
REQ-019 st (00010): T3-T5 as ld; T6 Gra,Rout,MDRin with MD_read=0; T7 ram_write; then T0.
REQ-020 add 00011, sub 00100, and 01010, or 01011: T3 Grb,Rout,Yin; T4 Grc,Rout,Zin with matching alu_op; T5 Zlowout,Gra,Rin; then T0.
REQ-021 addi (01100): T3 Grb,Rout,Yin; T4 Cout,Zin,ADD; T5 Zlowout,Gra,Rin; then T0.
REQ-022 halt (11011): T3 shall go to HALT; HALT shall hold all strobes at 0 with run=0 until clear.
REQ-023 nop (11010), and any undefined opcode, shall return from T3 to T0 with no strobes asserted in T3.
REQ-024 Exactly one of PCout, Zlowout, MDRout, Rout, BAout, Cout shall be asserted per cycle, or none.
REQ-025 Each instruction's cycle count (T0 to the next T0): ld/st 8, ldi/ALU/addi 6, nop 4.

Reset
REQ-026 clear=1 at a rising edge shall force state to RST from any state, including mid-instruction and HALT.
REQ-027 clear shall take priority over every other transition; no memory write shall issue in the cycle after clear is sampled.

Configuration
REQ-028 Macro CU_BRANCH_EN: when defined, opcode 10010 (br) executes T3 Gra,Rout,CONin; T4 PCout,Yin; T5 Cout,Zin,ADD; T6 Zlowout, with PCin only if con_ff=1; then T0.
REQ-029 When CU_BRANCH_EN is not defined, the CONin and con_ff ports shall be absent and opcode 10010 shall execute as nop.

Verification
REQ-030 clear for 1 cycle, then IR=0x0A000036 (ldi R4,#54) -> T3 Grb+BAout+Yin, T4 Cout+Zin, T5 Zlowout+Gra+Rin, T0 on cycle 6.
REQ-031 IR=0x11800034 (st R3,0x34(R0)) -> T6 Gra+Rout+MDRin with MD_read=0, T7 ram_write=1 for exactly one cycle.
REQ-032 IR=0x18918000 (add R1,R2,R3) -> T4 Grc+Rout+Zin with alu_op=0000; sub opcode gives alu_op=0001.
REQ-033 IR=0xD8000000 (halt) -> HALT with run=0 and all strobes 0 for 10 cycles; clear -> RST, then T0.
REQ-034 clear asserted during ld T5 -> RST on the next cycle; no ram_read is asserted in T6.
REQ-035 With CU_BRANCH_EN, br and con_ff=0 -> PCin=0 in T6; con_ff=1 -> PCin=1 with Zlowout in T6.

Source files
------------

// File: rtl/instr_control_unit.sv
// Hardwired Moore control unit: fetch (T0-T2), decode (T3), execute (T4-T7), HALT.
// Define CU_BRANCH_EN to add the conditional branch (br, opcode 10010) with CONin/con_ff.
module instr_control_unit (
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] instruction,
`ifdef CU_BRANCH_EN
   input  logic        con_ff,
   output logic        CONin,
`endif
   output logic        PCout,
   output logic        MARin,
   output logic        IncPC,
   output logic        PCin,
   output logic        Zin,
   output logic        Zlowout,
   output logic        Yin,
   output logic        MDRin,
   output logic        MDRout,
   output logic        MD_read,
   output logic        ram_read,
   output logic        ram_write,
   output logic        IRin,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic        Cout,
   output logic [3:0]  alu_op,
   output logic        run
);

   typedef enum logic [3:0] {
      S_RST  = 4'd0,
      S_T0   = 4'd1,
      S_T1   = 4'd2,
      S_T2   = 4'd3,
      S_T3   = 4'd4,
      S_T4   = 4'd5,
      S_T5   = 4'd6,
      S_T6   = 4'd7,
      S_T7   = 4'd8,
      S_HALT = 4'd9
   } state_e;

   typedef struct packed {
      logic       pc_out;
      logic       mar_in;
      logic       inc_pc;
      logic       pc_in;
      logic       z_in;
      logic       zlow_out;
      logic       y_in;
      logic       mdr_in;
      logic       mdr_out;
      logic       md_read;
      logic       ram_read;
      logic       ram_write;
      logic       ir_in;
      logic       gra;
      logic       grb;
      logic       grc;
      logic       r_in;
      logic       r_out;
      logic       ba_out;
      logic       c_out;
`ifdef CU_BRANCH_EN
      logic       con_in;
`endif
      logic [3:0] alu_op;
      logic       run;
   } ctrl_t;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b01010;
   localparam logic [4:0] OP_OR   = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_HALT = 5'b11011;
`ifdef CU_BRANCH_EN
   localparam logic [4:0] OP_BR   = 5'b10010;
`endif

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;

   state_e     state_q, state_d;
   logic [4:0] opcode_q, opcode_d;
   ctrl_t      ctrl_q, ctrl_d;
   logic       unused_ir_bits;

   assign unused_ir_bits = ^instruction[26:0];
   assign opcode_d = (state_q == S_T2) ? instruction[31:27] : opcode_q;

   // Strobes are decoded from the next state and registered, so outputs never see inputs combinationally.
   always_ff @(posedge clock) begin
      if (clear) begin
         state_q     <= S_RST;
         opcode_q    <= 5'b00000;
         ctrl_q      <= '0;
         ctrl_q.run  <= 1'b1;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         ctrl_q   <= ctrl_d;
      end
   end

   // Next-state sequencing; per-opcode length is decided in T3, T5 and T6.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RST: state_d = S_T0;
         S_T0:  state_d = S_T1;
         S_T1:  state_d = S_T2;
         S_T2:  state_d = S_T3;
         S_T3: begin
            case (opcode_q)
               OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: state_d = S_T4;
`ifdef CU_BRANCH_EN
               OP_BR:   state_d = S_T4;
`endif
               OP_HALT: state_d = S_HALT;
               default: state_d = S_T0;
            endcase
         end
         S_T4: state_d = S_T5;
         S_T5: begin
            case (opcode_q)
               OP_LD, OP_ST: state_d = S_T6;
`ifdef CU_BRANCH_EN
               OP_BR:        state_d = S_T6;
`endif
               default:      state_d = S_T0;
            endcase
         end
         S_T6: begin
            case (opcode_q)
               OP_LD, OP_ST: state_d = S_T7;
               default:      state_d = S_T0;
            endcase
         end
         S_T7:   state_d = S_T0;
         S_HALT: state_d = S_HALT;
         default: state_d = S_RST;
      endcase
   end

   // Strobe decode for the state about to be entered.
   always_comb begin
      ctrl_d        = '0;
      ctrl_d.run    = 1'b1;
      ctrl_d.alu_op = ALU_ADD;
      case (state_d)
         S_T0: begin
            ctrl_d.pc_out = 1'b1;
            ctrl_d.mar_in = 1'b1;
            ctrl_d.inc_pc = 1'b1;
            ctrl_d.z_in   = 1'b1;
         end
         S_T1: begin
            ctrl_d.zlow_out = 1'b1;
            ctrl_d.pc_in    = 1'b1;
            ctrl_d.ram_read = 1'b1;
            ctrl_d.md_read  = 1'b1;
            ctrl_d.mdr_in   = 1'b1;
         end
         S_T2: begin
            ctrl_d.mdr_out = 1'b1;
            ctrl_d.ir_in   = 1'b1;
         end
         S_T3: begin
            case (opcode_d)
               OP_LD, OP_LDI, OP_ST: begin
                  ctrl_d.grb    = 1'b1;
                  ctrl_d.ba_out = 1'b1;
                  ctrl_d.y_in   = 1'b1;
               end
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                  ctrl_d.grb   = 1'b1;
                  ctrl_d.r_out = 1'b1;
                  ctrl_d.y_in  = 1'b1;
               end
`ifdef CU_BRANCH_EN
               OP_BR: begin
                  ctrl_d.gra    = 1'b1;
                  ctrl_d.r_out  = 1'b1;
                  ctrl_d.con_in = 1'b1;
               end
`endif
               default: ctrl_d.run = 1'b1;
            endcase
         end
         S_T4: begin
            case (opcode_d)
               OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                  ctrl_d.grc   = 1'b1;
                  ctrl_d.r_out = 1'b1;
                  ctrl_d.z_in  = 1'b1;
                  case (opcode_d)
                     OP_SUB:  ctrl_d.alu_op = ALU_SUB;
                     OP_AND:  ctrl_d.alu_op = ALU_AND;
                     OP_OR:   ctrl_d.alu_op = ALU_OR;
                     default: ctrl_d.alu_op = ALU_ADD;
                  endcase
               end
`ifdef CU_BRANCH_EN
               OP_BR: begin
                  ctrl_d.pc_out = 1'b1;
                  ctrl_d.y_in   = 1'b1;
               end
`endif
               default: begin
                  ctrl_d.c_out = 1'b1;
                  ctrl_d.z_in  = 1'b1;
               end
            endcase
         end
         S_T5: begin
            case (opcode_d)
               OP_LD, OP_ST: begin
                  ctrl_d.zlow_out = 1'b1;
                  ctrl_d.mar_in   = 1'b1;
               end
`ifdef CU_BRANCH_EN
               OP_BR: begin
                  ctrl_d.c_out = 1'b1;
                  ctrl_d.z_in  = 1'b1;
               end
`endif
               default: begin
                  ctrl_d.zlow_out = 1'b1;
                  ctrl_d.gra      = 1'b1;
                  ctrl_d.r_in     = 1'b1;
               end
            endcase
         end
         S_T6: begin
            case (opcode_d)
               OP_LD: begin
                  ctrl_d.ram_read = 1'b1;
                  ctrl_d.md_read  = 1'b1;
                  ctrl_d.mdr_in   = 1'b1;
               end
               OP_ST: begin
                  ctrl_d.gra    = 1'b1;
                  ctrl_d.r_out  = 1'b1;
                  ctrl_d.mdr_in = 1'b1;
               end
`ifdef CU_BRANCH_EN
               OP_BR: begin
                  ctrl_d.zlow_out = 1'b1;
                  ctrl_d.pc_in    = con_ff;
               end
`endif
               default: ctrl_d.run = 1'b1;
            endcase
         end
         S_T7: begin
            case (opcode_d)
               OP_LD: begin
                  ctrl_d.mdr_out = 1'b1;
                  ctrl_d.gra     = 1'b1;
                  ctrl_d.r_in    = 1'b1;
               end
               OP_ST:   ctrl_d.ram_write = 1'b1;
               default: ctrl_d.run = 1'b1;
            endcase
         end
         S_HALT:  ctrl_d.run = 1'b0;
         default: ctrl_d.run = 1'b1;
      endcase
   end

   assign PCout     = ctrl_q.pc_out;
   assign MARin     = ctrl_q.mar_in;
   assign IncPC     = ctrl_q.inc_pc;
   assign PCin      = ctrl_q.pc_in;
   assign Zin       = ctrl_q.z_in;
   assign Zlowout   = ctrl_q.zlow_out;
   assign Yin       = ctrl_q.y_in;
   assign MDRin     = ctrl_q.mdr_in;
   assign MDRout    = ctrl_q.mdr_out;
   assign MD_read   = ctrl_q.md_read;
   assign ram_read  = ctrl_q.ram_read;
   assign ram_write = ctrl_q.ram_write;
   assign IRin      = ctrl_q.ir_in;
   assign Gra       = ctrl_q.gra;
   assign Grb       = ctrl_q.grb;
   assign Grc       = ctrl_q.grc;
   assign Rin       = ctrl_q.r_in;
   assign Rout      = ctrl_q.r_out;
   assign BAout     = ctrl_q.ba_out;
   assign Cout      = ctrl_q.c_out;
   assign alu_op    = ctrl_q.alu_op;
   assign run       = ctrl_q.run;
`ifdef CU_BRANCH_EN
   assign CONin     = ctrl_q.con_in;
`endif

endmodule
